// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch PC generator
package fetch_pkg;

   localparam int INSTR_BYTES = 4;
   localparam int IF_ID_W     = 32;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic               valid;
      logic [IF_ID_W-1:0] pc;
      logic [31:0]        instr;
      logic               predTaken;
      logic [IF_ID_W-1:0] predAddr;
   } if_id_t;

endpackage

// File: rtl/fetch_pc_gen_branch_resolve.sv
// rtl/fetch_pc_gen_branch_resolve.sv - EX-stage prediction check and fix-up PC
module branch_resolve
   import fetch_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             ex_valid,
   input  logic [WIDTH-1:0] ex_pc,
   input  logic             ex_pred_taken,
   input  logic [WIDTH-1:0] ex_pred_addr,
   input  logic             ex_branch,
   input  logic             ex_branch_taken,
   input  logic [WIDTH-1:0] ex_branch_addr,
   output logic             mispredict,
   output logic [WIDTH-1:0] fix_pc
);

   logic ok;

   // A non-branch carrying a taken prediction is a stale alias and must be undone.
   always_comb begin
      ok         = (ex_pred_taken == ex_branch_taken) &&
                   (!ex_branch_taken || (ex_pred_addr == ex_branch_addr));
      mispredict = 1'b0;
      if (ex_valid) begin
         mispredict = ex_branch ? !ok : ex_pred_taken;
      end
      fix_pc = (ex_branch_taken && ex_branch) ? ex_branch_addr
                                              : ex_pc + WIDTH'(INSTR_BYTES);
   end

endmodule

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC generator with IF/ID register; optional FETCH_PERF_CNT_EN counters
module fetch_pc_gen
   import fetch_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] PC,
   input  logic             predictJump,
   input  logic [WIDTH-1:0] jumpAddr,
   input  logic [31:0]      IMInstr,
   input  logic             Stall,
   output logic             IDValid,
   output logic [WIDTH-1:0] IDPC,
   output logic [31:0]      IDInstr,
   output logic             IDPredTaken,
   output logic [WIDTH-1:0] IDPredAddr,
   input  logic             EXValid,
   input  logic [WIDTH-1:0] EXPC,
   input  logic             EXPredTaken,
   input  logic [WIDTH-1:0] EXPredAddr,
   input  logic             EXBranch,
   input  logic             EXBranchTaken,
   input  logic [WIDTH-1:0] EXBranchAddr,
   input  logic             EXHalt,
   output logic             Redirect,
   output logic             Halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]      BranchCnt,
   output logic [31:0]      MispredCnt
`endif
);

   fetch_state_t     state_q, state_d;
   logic             halted_q, halted_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   if_id_t           if_id_q, if_id_d;
   logic             mispredict;
   logic [WIDTH-1:0] fix_pc;
   logic             halt_now;
   logic             redirect;

   branch_resolve #(.WIDTH(WIDTH)) u_resolve (
      .ex_valid        (EXValid),
      .ex_pc           (EXPC),
      .ex_pred_taken   (EXPredTaken),
      .ex_pred_addr    (EXPredAddr),
      .ex_branch       (EXBranch),
      .ex_branch_taken (EXBranchTaken),
      .ex_branch_addr  (EXBranchAddr),
      .mispredict      (mispredict),
      .fix_pc          (fix_pc)
   );

   // Next PC, IF/ID contents and FSM state; a halt beats a concurrent redirect.
   always_comb begin
      halt_now = EXValid && EXHalt;
      redirect = mispredict && (state_q != HALTED) && !EXHalt;

      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (halt_now) state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = BOOT;
      endcase
      halted_d = (state_d == HALTED);

      // BOOT holds RESET_PC so its fetch is captured once RUN begins.
      pc_d = pc_q;
      if (state_q == HALTED || halt_now) begin
         pc_d = pc_q;
      end else if (redirect) begin
         pc_d = fix_pc;
      end else if (Stall || state_q == BOOT) begin
         pc_d = pc_q;
      end else if (predictJump) begin
         pc_d = jumpAddr;
      end else begin
         pc_d = pc_q + WIDTH'(INSTR_BYTES);
      end

      if_id_d = if_id_q;
      if (redirect) begin
         if_id_d.valid = 1'b0;
      end else if (Stall) begin
         if_id_d = if_id_q;
      end else if (state_q != RUN) begin
         if_id_d.valid = 1'b0;
      end else begin
         if_id_d.valid     = 1'b1;
         if_id_d.pc        = IF_ID_W'(pc_q);
         if_id_d.instr     = IMInstr;
         if_id_d.predTaken = predictJump;
         if_id_d.predAddr  = IF_ID_W'(jumpAddr);
      end
   end

   // Fetch state registers; reset discards all in-flight fetch state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= BOOT;
         halted_q <= 1'b0;
         pc_q     <= RESET_PC;
         if_id_q  <= '0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
         pc_q     <= pc_d;
         if_id_q  <= if_id_d;
      end
   end

   assign PC          = pc_q;
   assign IDValid     = if_id_q.valid;
   assign IDPC        = WIDTH'(if_id_q.pc);
   assign IDInstr     = if_id_q.instr;
   assign IDPredTaken = if_id_q.predTaken;
   assign IDPredAddr  = WIDTH'(if_id_q.predAddr);
   assign Redirect    = redirect;
   assign Halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] branch_cnt_q, branch_cnt_d;
   logic [31:0] mispred_cnt_q, mispred_cnt_d;

   // Saturating event counters, frozen once the core has halted.
   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (state_q != HALTED) begin
         if (EXValid && EXBranch && (branch_cnt_q != 32'hFFFF_FFFF)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
         end
         if (redirect && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign BranchCnt  = branch_cnt_q;
   assign MispredCnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - self-checking bench for fetch_pc_gen
module tb_fetch_pc_gen;

   logic        clk;
   logic        rst;
   logic [31:0] PC;
   logic        predictJump;
   logic [31:0] jumpAddr;
   logic [31:0] IMInstr;
   logic        Stall;
   logic        IDValid;
   logic [31:0] IDPC;
   logic [31:0] IDInstr;
   logic        IDPredTaken;
   logic [31:0] IDPredAddr;
   logic        EXValid;
   logic [31:0] EXPC;
   logic        EXPredTaken;
   logic [31:0] EXPredAddr;
   logic        EXBranch;
   logic        EXBranchTaken;
   logic [31:0] EXBranchAddr;
   logic        EXHalt;
   logic        Redirect;
   logic        Halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] BranchCnt;
   logic [31:0] MispredCnt;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb_q[$];
   logic [31:0] exp_pc;

   fetch_pc_gen #(.WIDTH(32), .RESET_PC(32'h0000_0100)) dut (
      .clk           (clk),
      .rst           (rst),
      .PC            (PC),
      .predictJump   (predictJump),
      .jumpAddr      (jumpAddr),
      .IMInstr       (IMInstr),
      .Stall         (Stall),
      .IDValid       (IDValid),
      .IDPC          (IDPC),
      .IDInstr       (IDInstr),
      .IDPredTaken   (IDPredTaken),
      .IDPredAddr    (IDPredAddr),
      .EXValid       (EXValid),
      .EXPC          (EXPC),
      .EXPredTaken   (EXPredTaken),
      .EXPredAddr    (EXPredAddr),
      .EXBranch      (EXBranch),
      .EXBranchTaken (EXBranchTaken),
      .EXBranchAddr  (EXBranchAddr),
      .EXHalt        (EXHalt),
      .Redirect      (Redirect),
      .Halted        (Halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .BranchCnt     (BranchCnt),
      .MispredCnt    (MispredCnt)
`endif
   );

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hDEAD_0013;
   endfunction

   assign IMInstr = instr_of(PC);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         exp_pc = sb_q.pop_front();
         checks++;
         if (PC !== exp_pc) begin
            errors++;
            $display("FAIL sb_pc got %h exp %h at %0t", PC, exp_pc, $time);
         end
      end
   end

   task automatic clear_ex();
      EXValid = 0; EXPC = 0; EXPredTaken = 0; EXPredAddr = 0;
      EXBranch = 0; EXBranchTaken = 0; EXBranchAddr = 0; EXHalt = 0;
   endtask

   task automatic test_reset();
      rst = 0; predictJump = 0; jumpAddr = 0; Stall = 0;
      clear_ex();
      repeat (2) @(posedge clk);
      #2;
      checks++; if (PC !== 32'h100) begin errors++; $display("FAIL rst_pc got %h exp %h", PC, 32'h100); end
      checks++; if ({IDValid, IDPredTaken} !== 2'b00) begin errors++; $display("FAIL rst_idflags got %b exp 00", {IDValid, IDPredTaken}); end
      checks++; if ({IDPC, IDInstr, IDPredAddr} !== 96'h0) begin errors++; $display("FAIL rst_idfields got %h exp 0", {IDPC, IDInstr, IDPredAddr}); end
      checks++; if ({Halted, Redirect} !== 2'b00) begin errors++; $display("FAIL rst_halt got %b exp 00", {Halted, Redirect}); end
      @(negedge clk); rst = 1; sb_q.push_back(32'h100);
      @(posedge clk); #2;
      checks++; if (IDValid !== 1'b0) begin errors++; $display("FAIL boot_bubble got %b exp 0", IDValid); end
      @(negedge clk); sb_q.push_back(32'h104);
      @(posedge clk); #2;
      checks++; if (IDValid !== 1'b1 || IDPC !== 32'h100) begin errors++; $display("FAIL first_fetch got %b/%h exp 1/100", IDValid, IDPC); end
      checks++; if (IDInstr !== instr_of(32'h100)) begin errors++; $display("FAIL first_instr got %h exp %h", IDInstr, instr_of(32'h100)); end
      @(negedge clk); sb_q.push_back(32'h108);
      @(posedge clk);
`ifdef FETCH_PERF_CNT_EN
      #2;
      checks++; if (BranchCnt !== 0 || MispredCnt !== 0) begin errors++; $display("FAIL rst_cnt got %h/%h exp 0/0", BranchCnt, MispredCnt); end
`endif
   endtask

   task automatic test_predict();
      @(negedge clk); predictJump = 1; jumpAddr = 32'h200; sb_q.push_back(32'h200);
      @(posedge clk); #2;
      checks++; if (IDPC !== 32'h108) begin errors++; $display("FAIL pred_idpc0 got %h exp 108", IDPC); end
      @(negedge clk); jumpAddr = 32'h400; sb_q.push_back(32'h400);
      @(posedge clk); #2;
      checks++; if (IDPC !== 32'h200 || IDPredTaken !== 1'b1 || IDPredAddr !== 32'h400) begin
         errors++; $display("FAIL pred_meta got %h/%b/%h exp 200/1/400", IDPC, IDPredTaken, IDPredAddr);
      end
      @(negedge clk); predictJump = 0; jumpAddr = 0;
   endtask

   task automatic test_mispredict_stall();
      EXValid = 1; EXBranch = 1; EXPredTaken = 0; EXBranchTaken = 1;
      EXBranchAddr = 32'h80; EXPC = 32'h50; Stall = 1;
      #1;
      checks++; if (Redirect !== 1'b1) begin errors++; $display("FAIL misp_redirect got %b exp 1", Redirect); end
      sb_q.push_back(32'h80);
      @(posedge clk); #2;
      checks++; if (IDValid !== 1'b0) begin errors++; $display("FAIL misp_flush got %b exp 0", IDValid); end
      @(negedge clk); clear_ex(); Stall = 0; sb_q.push_back(32'h84);
      @(posedge clk); #2;
      checks++; if (IDValid !== 1'b1 || IDPC !== 32'h80) begin errors++; $display("FAIL fix_fetch got %b/%h exp 1/80", IDValid, IDPC); end
      @(negedge clk); Stall = 1; sb_q.push_back(32'h84);
      @(posedge clk); #2;
      checks++; if (IDValid !== 1'b1 || IDPC !== 32'h80) begin errors++; $display("FAIL stall_hold got %b/%h exp 1/80", IDValid, IDPC); end
      @(negedge clk); Stall = 0;
   endtask

   task automatic test_stale_alias();
      EXValid = 1; EXBranch = 0; EXPredTaken = 1; EXPC = 32'h300;
      #1;
      checks++; if (Redirect !== 1'b1) begin errors++; $display("FAIL alias_redirect got %b exp 1", Redirect); end
      sb_q.push_back(32'h304);
      @(posedge clk); #2;
      checks++; if (IDValid !== 1'b0) begin errors++; $display("FAIL alias_flush got %b exp 0", IDValid); end
      @(negedge clk);
      EXBranch = 1; EXBranchTaken = 1; EXPredAddr = 32'h500; EXBranchAddr = 32'h500; EXPC = 32'h310;
      #1;
      checks++; if (Redirect !== 1'b0) begin errors++; $display("FAIL match_taken got %b exp 0", Redirect); end
      sb_q.push_back(32'h308);
      @(posedge clk);
      @(negedge clk);
      EXPredTaken = 0; EXBranchTaken = 0; EXPredAddr = 32'h10; EXBranchAddr = 32'h20;
      #1;
      checks++; if (Redirect !== 1'b0) begin errors++; $display("FAIL match_nottaken got %b exp 0", Redirect); end
      sb_q.push_back(32'h30C);
      @(posedge clk);
      @(negedge clk);
      EXValid = 0; EXBranch = 0; EXPredTaken = 1;
      #1;
      checks++; if (Redirect !== 1'b0) begin errors++; $display("FAIL invalid_ex got %b exp 0", Redirect); end
      sb_q.push_back(32'h310);
      @(posedge clk);
      @(negedge clk); clear_ex();
   endtask

   task automatic test_back_to_back();
      EXValid = 1; EXBranch = 1; EXPredTaken = 1; EXPredAddr = 32'h10;
      EXBranchTaken = 1; EXBranchAddr = 32'h1000;
      #1;
      checks++; if (Redirect !== 1'b1) begin errors++; $display("FAIL wrong_target got %b exp 1", Redirect); end
      sb_q.push_back(32'h1000);
      @(posedge clk);
      @(negedge clk);
      EXPredTaken = 1; EXBranchTaken = 0; EXPC = 32'h2000; EXPredAddr = 32'h2000;
      #1;
      checks++; if (Redirect !== 1'b1) begin errors++; $display("FAIL false_taken got %b exp 1", Redirect); end
      sb_q.push_back(32'h2004);
      @(posedge clk); #2;
      checks++; if (IDValid !== 1'b0) begin errors++; $display("FAIL b2b_flush got %b exp 0", IDValid); end
      @(negedge clk); clear_ex(); sb_q.push_back(32'h2008);
      @(posedge clk); #2;
      checks++; if (IDValid !== 1'b1 || IDPC !== 32'h2004 || IDInstr !== instr_of(32'h2004)) begin
         errors++; $display("FAIL b2b_fetch got %b/%h/%h exp 1/2004/%h", IDValid, IDPC, IDInstr, instr_of(32'h2004));
      end
   endtask

   task automatic test_halt();
      @(negedge clk);
      EXValid = 1; EXHalt = 1; EXBranch = 1; EXPredTaken = 0; EXBranchTaken = 1; EXBranchAddr = 32'h80;
      #1;
      checks++; if (Redirect !== 1'b0) begin errors++; $display("FAIL halt_beats_redirect got %b exp 0", Redirect); end
      sb_q.push_back(32'h2008);
      @(posedge clk); #2;
      checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halted got %b exp 1", Halted); end
      @(negedge clk);
      EXHalt = 0; EXBranch = 0; EXPredTaken = 1; EXPC = 32'h40; predictJump = 1; jumpAddr = 32'h999;
      #1;
      checks++; if (Redirect !== 1'b0) begin errors++; $display("FAIL halted_redirect got %b exp 0", Redirect); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); sb_q.push_back(32'h2008);
         @(posedge clk);
      end
      #2;
      checks++; if (IDValid !== 1'b0 || Halted !== 1'b1) begin errors++; $display("FAIL halted_hold got %b/%b exp 0/1", IDValid, Halted); end
      @(negedge clk); rst = 0; clear_ex(); predictJump = 0; jumpAddr = 0;
      @(posedge clk); #2;
      checks++; if (PC !== 32'h100 || Halted !== 1'b0 || IDValid !== 1'b0) begin
         errors++; $display("FAIL halt_reset got %h/%b/%b exp 100/0/0", PC, Halted, IDValid);
      end
   endtask

   task automatic test_wrap_perf();
      @(negedge clk); rst = 1; sb_q.push_back(32'h100);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         EXValid = 1; EXBranch = 1; EXPredTaken = 1; EXBranchTaken = 1;
         EXPredAddr = 32'h700; EXBranchAddr = 32'h700;
         #1;
         checks++; if (Redirect !== 1'b0) begin errors++; $display("FAIL perf_hit%0d got %b exp 0", i, Redirect); end
         sb_q.push_back(32'h104 + 32'(4 * i));
         @(posedge clk);
      end
      @(negedge clk);
      EXPredTaken = 0; EXBranchTaken = 1; EXBranchAddr = 32'hFFFF_FFFC;
      #1;
      checks++; if (Redirect !== 1'b1) begin errors++; $display("FAIL perf_miss got %b exp 1", Redirect); end
      sb_q.push_back(32'hFFFF_FFFC);
      @(posedge clk);
      @(negedge clk); clear_ex(); sb_q.push_back(32'h0000_0000);
      @(posedge clk); #2;
      checks++; if (IDValid !== 1'b1 || IDPC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fetch got %b/%h exp 1/fffffffc", IDValid, IDPC); end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (BranchCnt !== 32'd3 || MispredCnt !== 32'd1) begin errors++; $display("FAIL perf_cnt got %0d/%0d exp 3/1", BranchCnt, MispredCnt); end
`endif
      @(negedge clk); sb_q.push_back(32'h0000_0004);
      @(posedge clk); #2;
   endtask

   initial begin
      test_reset();
      test_predict();
      test_mispredict_stall();
      test_stale_alias();
      test_back_to_back();
      test_halt();
      test_wrap_perf();
      @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++; $display("FAIL sb_drain got %0d exp 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
